// File: rtl/onehot_event_encoder8x3.sv
// Serialises an 8-bit event vector into the 3-bit binary index of each set bit,
// one beat per valid/ready handshake, in fixed LSB-first or MSB-first priority order.
module onehot_event_encoder8x3 #(
    parameter int N            = 8,
    parameter int IDXW         = 3,
    parameter bit PRIORITY_LSB = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic            zero_drop,
    output logic            busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic            zero_drop_q, zero_drop_d;
    logic [IDXW-1:0] prio_idx;
    logic [N-1:0]    prio_mask;
    logic            single_bit;

    // The last assignment in the scan wins, so the scan direction sets the priority.
    always_comb begin
        prio_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (PRIORITY_LSB) begin
                if (pending_q[N-1-i]) prio_idx = IDXW'(N-1-i);
            end else begin
                if (pending_q[i]) prio_idx = IDXW'(i);
            end
        end
        prio_mask           = '0;
        prio_mask[prio_idx] = 1'b1;
        single_bit          = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        zero_drop_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_vec != '0) begin
                        pending_d = in_vec;
                        state_d   = DRAIN;
                    end else begin
                        zero_drop_d = 1'b1;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    pending_d = pending_q & ~prio_mask;
                    if (single_bit) state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    // Outputs depend only on registered state, never on in_vec.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == DRAIN);
    assign out_idx   = out_valid ? prio_idx : '0;
    assign out_last  = out_valid && single_bit;
    assign zero_drop = zero_drop_q;

endmodule

// File: tb/tb_onehot_event_encoder8x3.sv
// Drives an LSB-first and an MSB-first encoder with shared stimulus and compares
// both against queue-based reference models of the emitted index sequence.
module tb_onehot_event_encoder8x3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_vec = '0;
    logic       out_ready = 1'b0;

    logic       in_ready_l, out_valid_l, out_last_l, zero_drop_l, busy_l;
    logic [2:0] out_idx_l;
    logic       in_ready_m, out_valid_m, out_last_m, zero_drop_m, busy_m;
    logic [2:0] out_idx_m;

    int checks = 0;
    int errors = 0;

    int q_lsb[$];
    int q_msb[$];
    bit exp_zd = 1'b0;

    always #5 clk = ~clk;

    onehot_event_encoder8x3 #(.PRIORITY_LSB(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_idx(out_idx_l), .out_last(out_last_l), .zero_drop(zero_drop_l), .busy(busy_l)
    );

    onehot_event_encoder8x3 #(.PRIORITY_LSB(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_idx(out_idx_m), .out_last(out_last_m), .zero_drop(zero_drop_m), .busy(busy_m)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic checkSide(input string side, input int size, input int front,
                             input logic ov, input logic [2:0] oi, input logic ol,
                             input logic ir, input logic zd, input logic bz);
        checkOutput({side, ".out_valid"}, int'(ov), int'(size > 0));
        checkOutput({side, ".out_idx"},   int'(oi), (size > 0) ? front : 0);
        checkOutput({side, ".out_last"},  int'(ol), int'(size == 1));
        checkOutput({side, ".in_ready"},  int'(ir), int'(size == 0));
        checkOutput({side, ".busy"},      int'(bz), int'(size > 0));
        checkOutput({side, ".zero_drop"}, int'(zd), int'(exp_zd));
    endtask

    task automatic checkAll();
        checkSide("lsb", q_lsb.size(), (q_lsb.size() > 0) ? q_lsb[0] : 0,
                  out_valid_l, out_idx_l, out_last_l, in_ready_l, zero_drop_l, busy_l);
        checkSide("msb", q_msb.size(), (q_msb.size() > 0) ? q_msb[0] : 0,
                  out_valid_m, out_idx_m, out_last_m, in_ready_m, zero_drop_m, busy_m);
    endtask

    // Reference: an accepted vector becomes the list of its set-bit indices in emission order.
    task automatic modelStep();
        bit idle;
        if (!rst_n) begin
            q_lsb.delete();
            q_msb.delete();
            exp_zd = 1'b0;
            return;
        end
        idle   = (q_lsb.size() == 0);
        exp_zd = 1'b0;
        if (idle) begin
            if (in_valid) begin
                if (in_vec == 8'h00) exp_zd = 1'b1;
                else begin
                    for (int i = 0; i < 8; i++) begin
                        if (in_vec[i]) begin
                            q_lsb.push_back(i);
                            q_msb.push_front(i);
                        end
                    end
                end
            end
        end else if (out_ready) begin
            void'(q_lsb.pop_front());
            void'(q_msb.pop_front());
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] vec, input logic rdy);
        in_valid  = v;
        in_vec    = vec;
        out_ready = rdy;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    initial begin
        $display("[TB] start");
        // Reset held: inputs must be ignored.
        applyStimulus(1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b1);
        #2 rst_n = 1'b1;

        // Sparse vector, full throughput, then backpressure on a two-hot vector.
        applyStimulus(1'b1, 8'b1010_0100, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'h81, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);

        // All-zero vector is dropped with a single-cycle pulse.
        applyStimulus(1'b1, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Full vector, reset after two beats, then a single-bit vector.
        applyStimulus(1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        rst_n = 1'b0;
        modelStep();
        #1;
        checkAll();
        applyStimulus(1'b1, 8'h55, 1'b1);
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 8'h10, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);

        // Random traffic, including in_vec churn during drain and zero vectors.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] rv;
            case ($urandom_range(0, 3))
                0: rv = 8'h00;
                1: rv = 8'h01 << $urandom_range(0, 7);
                default: rv = 8'($urandom);
            endcase
            applyStimulus(1'($urandom_range(0, 1)), rv, ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
